strobe_spi_master: RTL

- SPI master for the EMG front-end serial link, paced by the 2 MHz strobe (one-clk pulse every 10 cycles of the 20 MHz system clock).
- Sits directly downstream of the strobe generator: it does nothing except on clk cycles where twoMHz_stb is high, which gives a 1 MHz SCLK.
- Shifts a WIDTH-bit command out on MOSI while capturing WIDTH bits from MISO.
- Uses a start/busy/done handshake toward the sequencer.

---
 rtl/strobe_spi_master.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/strobe_spi_master.sv
// Mode-0 SPI master for the EMG front-end link. All serial timing advances only on
// twoMHz_stb, so SCLK runs at half the strobe rate and freezes cleanly when the strobe stops.
module strobe_spi_master #(
    parameter int WIDTH    = 32,
    parameter int CS_SETUP = 1,
    parameter int IDLE_GAP = 1
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             twoMHz_stb,
    input  logic             start,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             miso,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] rx_data,
    output logic             sclk,
    output logic             cs_n,
    output logic             mosi
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_GAP
    } state_t;

    localparam int BW   = $clog2(WIDTH);
    localparam int TMAX = (CS_SETUP > IDLE_GAP) ? CS_SETUP : IDLE_GAP;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [BW-1:0] BIT_LAST   = BW'(WIDTH - 1);
    localparam logic [TW-1:0] SETUP_LAST = TW'(CS_SETUP - 1);
    localparam logic [TW-1:0] GAP_LAST   = (IDLE_GAP > 0) ? TW'(IDLE_GAP - 1) : '0;

    state_t           state, state_nxt;
    logic [TW-1:0]    tick_cnt, tick_nxt;
    logic [BW-1:0]    bit_cnt, bit_nxt;
    logic [WIDTH-1:0] tx_sr, tx_nxt, tx_shift;
    logic [WIDTH-1:0] rx_sr, rx_sr_nxt;
    logic [WIDTH-1:0] rx_data_nxt;
    logic             sclk_nxt, cs_n_nxt, mosi_nxt, busy_nxt, done_nxt;

    logic setup_last, gap_last, bit_last;

    assign setup_last = (tick_cnt == SETUP_LAST);
    assign gap_last   = (tick_cnt == GAP_LAST);
    assign bit_last   = (bit_cnt == BIT_LAST);
    assign tx_shift   = tx_sr << 1;

    // State and every registered output live here; reset aborts any transfer in flight.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state    <= S_IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            rx_data  <= '0;
            sclk     <= 1'b0;
            cs_n     <= 1'b1;
            mosi     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            tick_cnt <= tick_nxt;
            bit_cnt  <= bit_nxt;
            tx_sr    <= tx_nxt;
            rx_sr    <= rx_sr_nxt;
            rx_data  <= rx_data_nxt;
            sclk     <= sclk_nxt;
            cs_n     <= cs_n_nxt;
            mosi     <= mosi_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_SETUP;
            S_SETUP: if (twoMHz_stb && setup_last) state_nxt = S_SHIFT;
            S_SHIFT: if (twoMHz_stb && sclk && bit_last) state_nxt = S_HOLD;
            S_HOLD:  if (twoMHz_stb) state_nxt = (IDLE_GAP == 0) ? S_IDLE : S_GAP;
            S_GAP:   if (twoMHz_stb && gap_last) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        tick_nxt    = tick_cnt;
        bit_nxt     = bit_cnt;
        tx_nxt      = tx_sr;
        rx_sr_nxt   = rx_sr;
        rx_data_nxt = rx_data;
        sclk_nxt    = sclk;
        cs_n_nxt    = cs_n;
        mosi_nxt    = mosi;
        busy_nxt    = busy;
        done_nxt    = 1'b0;
        case (state)
            S_IDLE: begin
                // Acceptance ignores the strobe, so a coincident tick is not counted.
                if (start) begin
                    tx_nxt   = tx_data;
                    mosi_nxt = tx_data[WIDTH-1];
                    cs_n_nxt = 1'b0;
                    busy_nxt = 1'b1;
                    bit_nxt  = '0;
                    tick_nxt = '0;
                end
            end
            S_SETUP: begin
                if (twoMHz_stb) tick_nxt = setup_last ? '0 : tick_cnt + 1'b1;
            end
            S_SHIFT: begin
                if (twoMHz_stb) begin
                    if (!sclk) begin
                        sclk_nxt  = 1'b1;
                        rx_sr_nxt = {rx_sr[WIDTH-2:0], miso};
                    end else begin
                        sclk_nxt = 1'b0;
                        // MOSI moves only on the falling edge, and not after the last bit.
                        if (!bit_last) begin
                            bit_nxt  = bit_cnt + 1'b1;
                            tx_nxt   = tx_shift;
                            mosi_nxt = tx_shift[WIDTH-1];
                        end
                    end
                end
            end
            S_HOLD: begin
                if (twoMHz_stb) begin
                    cs_n_nxt    = 1'b1;
                    mosi_nxt    = 1'b0;
                    rx_data_nxt = rx_sr;
                    done_nxt    = 1'b1;
                    if (IDLE_GAP == 0) busy_nxt = 1'b0;
                end
            end
            S_GAP: begin
                if (twoMHz_stb) begin
                    if (gap_last) begin
                        tick_nxt = '0;
                        busy_nxt = 1'b0;
                    end else begin
                        tick_nxt = tick_cnt + 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

endmodule
